// File: rtl/mem_if_pkg.sv
// Shared types for the cache-to-memory line master: line operations and FSM states.
package mem_if_pkg;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      OP_NONE    = 2'b00,
      OP_FILL    = 2'b01,
      OP_WB      = 2'b10,
      OP_WB_FILL = 2'b11
   } mem_op_e;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WB        = 2'b01,
      FILL      = 2'b10,
      FILL_TAIL = 2'b11
   } mls_state_e;
endpackage

// File: rtl/mem_line_master.sv
// Turns one line-level fill / write-back / write-back-then-fill request into per-word
// accesses on a single-port synchronous word memory with 1-cycle read latency.
module mem_line_master
   import mem_if_pkg::*;
#(
   parameter int ADDR_LEN      = 11,
   parameter int LINE_ADDR_LEN = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   input  logic [1:0]                    req_op,
   input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0] req_wb_line,
   input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0] req_fill_line,
   output logic                          req_ready,
   output logic [LINE_ADDR_LEN-1:0]      wb_word_idx,
   input  logic [DATA_W-1:0]             wb_word_data,
   output logic                          rd_word_valid,
   output logic [LINE_ADDR_LEN-1:0]      rd_word_idx,
   output logic [DATA_W-1:0]             rd_word_data,
   output logic                          done,
   output logic [ADDR_LEN-1:0]           mem_addr,
   output logic                          mem_wr_req,
   output logic [DATA_W-1:0]             mem_wr_data,
   input  logic [DATA_W-1:0]             mem_rd_data
);
   localparam int LINE_W = ADDR_LEN - LINE_ADDR_LEN;
   localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = {LINE_ADDR_LEN{1'b1}};
   localparam logic [LINE_ADDR_LEN-1:0] CNT_ONE  = LINE_ADDR_LEN'(1);

   mls_state_e               state_q;
   mem_op_e                  op_q;
   logic [LINE_ADDR_LEN-1:0] cnt_q;
   logic [LINE_W-1:0]        wb_line_q;
   logic [LINE_W-1:0]        fill_line_q;

   // Line FSM: counter wraps to 0 at the end of each phase, so WB hands straight over to FILL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_NONE;
         cnt_q       <= '0;
         wb_line_q   <= '0;
         fill_line_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && (req_op != 2'b00)) begin
                  op_q        <= mem_op_e'(req_op);
                  wb_line_q   <= req_wb_line;
                  fill_line_q <= req_fill_line;
                  cnt_q       <= '0;
                  state_q     <= (mem_op_e'(req_op) == OP_FILL) ? FILL : WB;
               end else begin
                  state_q <= IDLE;
               end
            end
            WB: begin
               cnt_q <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_q <= (op_q == OP_WB_FILL) ? FILL : IDLE;
               end else begin
                  state_q <= WB;
               end
            end
            FILL: begin
               cnt_q <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_q <= FILL_TAIL;
               end else begin
                  state_q <= FILL;
               end
            end
            FILL_TAIL: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Output decode straight from state/counter; fill data is the memory's registered read port.
   always_comb begin
      req_ready     = 1'b0;
      wb_word_idx   = '0;
      rd_word_valid = 1'b0;
      rd_word_idx   = '0;
      rd_word_data  = mem_rd_data;
      done          = 1'b0;
      mem_addr      = '0;
      mem_wr_req    = 1'b0;
      mem_wr_data   = '0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
         end
         WB: begin
            mem_addr    = {wb_line_q, cnt_q};
            mem_wr_req  = 1'b1;
            wb_word_idx = cnt_q;
            mem_wr_data = wb_word_data;
            done        = (cnt_q == CNT_LAST) && (op_q == OP_WB);
         end
         FILL: begin
            mem_addr      = {fill_line_q, cnt_q};
            rd_word_valid = (cnt_q != '0);
            rd_word_idx   = cnt_q - CNT_ONE;
         end
         FILL_TAIL: begin
            mem_addr      = {fill_line_q, CNT_LAST};
            rd_word_valid = 1'b1;
            rd_word_idx   = CNT_LAST;
            done          = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench: real synchronous memory model plus a reference copy of its contents.
module tb_mem_line_master;
   import mem_if_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'b00;
   logic [7:0]  req_wb_line = 8'd0;
   logic [7:0]  req_fill_line = 8'd0;
   logic        req_ready;
   logic [2:0]  wb_word_idx;
   logic [31:0] wb_word_data;
   logic        rd_word_valid;
   logic [2:0]  rd_word_idx;
   logic [31:0] rd_word_data;
   logic        done;
   logic [10:0] mem_addr;
   logic        mem_wr_req;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   logic [31:0] mem [0:2047];
   logic [31:0] ref_mem [0:2047];
   logic        preload = 1'b1;
   logic [31:0] wb_base = 32'h0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign wb_word_data = wb_base + {29'd0, wb_word_idx};

   // Single-port word memory: registered read, write lands at the clock edge.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 32'h1000 + i;
      end else if (mem_wr_req) begin
         mem[mem_addr] <= mem_wr_data;
      end
      if (!rst_n) mem_rd_data <= 32'h0;
      else        mem_rd_data <= mem[mem_addr];
   end

   mem_line_master #(.ADDR_LEN(11), .LINE_ADDR_LEN(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_op(req_op),
      .req_wb_line(req_wb_line), .req_fill_line(req_fill_line),
      .req_ready(req_ready),
      .wb_word_idx(wb_word_idx), .wb_word_data(wb_word_data),
      .rd_word_valid(rd_word_valid), .rd_word_idx(rd_word_idx), .rd_word_data(rd_word_data),
      .done(done),
      .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Called at the first negedge after acceptance; returns at the negedge of the done cycle.
   task automatic run_burst(input logic [1:0] op, input logic [7:0] wbl, input logic [7:0] fl,
                            input int exp_lat, input logic hold_next, input logic [7:0] next_fl,
                            input string tag);
      int cyc = 1;
      int wrs = 0;
      int rds = 0;
      int seen_done = 0;
      if (op[1]) begin
         for (int i = 0; i < 8; i++) ref_mem[{wbl, i[2:0]}] = wb_base + i;
      end
      while (cyc <= 40 && seen_done == 0) begin
         if (mem_wr_req) begin
            check_eq({tag, " wr_addr"}, {21'd0, mem_addr}, {21'd0, wbl, wrs[2:0]});
            check_eq({tag, " wr_data"}, mem_wr_data, wb_base + wrs);
            wrs++;
         end
         if (rd_word_valid) begin
            check_eq({tag, " rd_idx"}, {29'd0, rd_word_idx}, rds);
            check_eq({tag, " rd_data"}, rd_word_data, ref_mem[{fl, rds[2:0]}]);
            rds++;
         end
         if (done) begin
            seen_done = 1;
            check_eq({tag, " latency"}, cyc, exp_lat);
            if (hold_next) req_fill_line = next_fl;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check_eq({tag, " done_seen"}, seen_done, 1);
      check_eq({tag, " wr_count"}, wrs, op[1] ? 8 : 0);
      check_eq({tag, " rd_count"}, rds, op[0] ? 8 : 0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] wbl, input logic [7:0] fl,
                        input int exp_lat, input string tag);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_wb_line = wbl; req_fill_line = fl;
      check_eq({tag, " ready"}, req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0; req_op = 2'b00;
      run_burst(op, wbl, fl, exp_lat, 1'b0, 8'd0, tag);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h1000 + i;
      repeat (2) @(negedge clk);
      check_eq("rst ready", req_ready, 1);
      check_eq("rst wr_req", mem_wr_req, 0);
      check_eq("rst rd_valid", rd_word_valid, 0);
      check_eq("rst done", done, 0);
      check_eq("rst addr", {21'd0, mem_addr}, 0);
      check_eq("rst wb_idx", {29'd0, wb_word_idx}, 0);
      preload = 1'b0;
      rst_n = 1'b1;

      issue(2'b01, 8'd0, 8'd5, 9, "fill5");

      wb_base = 32'hA0;
      issue(2'b10, 8'd2, 8'd0, 8, "wb2");
      issue(2'b01, 8'd0, 8'd2, 9, "fill2");

      wb_base = 32'hB0;
      issue(2'b11, 8'd3, 8'd3, 17, "wbfill3");

      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00;
      for (int k = 0; k < 3; k++) begin
         check_eq("op00 ready", req_ready, 1);
         check_eq("op00 wr_req", mem_wr_req, 0);
         check_eq("op00 done", done, 0);
         check_eq("op00 rd_valid", rd_word_valid, 0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      check_eq("op00 after ready", req_ready, 1);

      // Reset in the fourth FILL cycle.
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_fill_line = 8'd6;
      @(negedge clk);
      req_valid = 1'b0; req_op = 2'b00;
      repeat (3) @(negedge clk);
      check_eq("pre_rst rd_valid", rd_word_valid, 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst wr_req", mem_wr_req, 0);
      check_eq("mid_rst rd_valid", rd_word_valid, 0);
      check_eq("mid_rst ready", req_ready, 1);
      check_eq("mid_rst addr", {21'd0, mem_addr}, 0);
      repeat (2) @(negedge clk);
      check_eq("in_rst done", done, 0);
      rst_n = 1'b1;
      issue(2'b01, 8'd0, 8'd1, 9, "fill1_after_rst");

      // Back-to-back with req_valid held throughout.
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_fill_line = 8'd0;
      @(negedge clk);
      run_burst(2'b01, 8'd0, 8'd0, 9, 1'b1, 8'd1, "b2b_fill0");
      check_eq("b2b ready in done", req_ready, 0);
      @(negedge clk);
      check_eq("b2b ready after done", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0; req_op = 2'b00;
      run_burst(2'b01, 8'd0, 8'd1, 9, 1'b0, 8'd0, "b2b_fill1");

      @(negedge clk);
      check_eq("end ready", req_ready, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
